sdram_port_sched: RTL and testbench

- Shares one toggle-handshake SDRAM port between two requesters: the ROM download byte writer and the vector-generator RAM.
- Converts the level/strobe-style requests on each side into single outstanding SDRAM transactions.
- Latches read data back for the vector RAM and flags when ROM loading has completed.
- Sits between data_io / LLANDER_TOP and the sdram controller in the core top level, in the 72 MHz memory clock domain.

---
 rtl/sdram_sched_pkg.sv | 26 ++
 rtl/sdram_req_slot.sv | 58 +++++
 rtl/sdram_port_sched.sv | 252 +++++++++++++++++++++++++
 tb/tb_sdram_port_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_sched_pkg.sv
// Shared types for the SDRAM port scheduler: FSM states and the request
// record driven onto the toggle-handshake SDRAM port.
package sdram_sched_pkg;

  localparam int SD_AW = 23;
  localparam int SD_DW = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_DL = 2'd1,
    WAIT_VR = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [SD_AW-1:0] a;
    logic [1:0]       ds;
    logic             we;
    logic [SD_DW-1:0] d;
  } sd_req_t;

  // Byte lane for a download byte: odd byte addresses land in the high lane.
  function automatic logic [1:0] dl_lane(input logic a0);
    return {a0, ~a0};
  endfunction

endpackage

// File: rtl/sdram_req_slot.sv
// One-deep pending request register. A capture always wins over a clear in
// the same cycle, so a request arriving while the previous one is being
// issued stays pending. Overwriting a still-unissued entry sets a sticky
// overrun flag.
module sdram_req_slot
  import sdram_sched_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  input  logic         cap,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic         full,
  output logic [W-1:0] dout,
  output logic         ovr
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;
  logic         ovr_q, ovr_d;

  // Next-state for occupancy, payload and overrun.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    ovr_d  = ovr_q;
    if (clr) begin
      full_d = 1'b0;
    end
    if (cap) begin
      full_d = 1'b1;
      data_d = din;
      if (full_q && !clr) begin
        ovr_d = 1'b1;
      end
    end
  end

  // Slot registers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      ovr_q  <= ovr_d;
    end
  end

  assign full = full_q;
  assign dout = data_q;
  assign ovr  = ovr_q;

endmodule

// File: rtl/sdram_port_sched.sv
// SDRAM port scheduler: shares one toggle-handshake SDRAM port between the
// ROM download byte writer and the vector-generator RAM, one transaction
// outstanding at a time, download side first.
//
// Optional build macro: SDRAM_PORT_SCHED_RDCACHE_EN -- a vector read of the
// last completed read address, with no write issued since, completes
// locally without touching SDRAM.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no access in flight; issue DL slot, else VR slot if allowed
// WAIT_DL | download byte write in flight, waiting for ack toggle
// WAIT_VR | vector RAM access in flight, waiting for ack toggle
module sdram_port_sched
  import sdram_sched_pkg::*;
#(
  parameter int               VR_AW   = 10,
  parameter logic [SD_AW-1:0] VR_BASE = 23'h010000
) (
  input  logic              clk_sys,
  input  logic              RESET_L,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [23:0]       dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_overrun,
  output logic              rom_loaded,
  input  logic [1:0]        vr_cs,
  input  logic              vr_we,
  input  logic [VR_AW-1:0]  vr_addr,
  input  logic [15:0]       vr_din,
  output logic [15:0]       vr_dout,
  output logic              vr_busy,
  output logic              sd_req,
  input  logic              sd_ack,
  output logic [SD_AW-1:0]  sd_a,
  output logic [1:0]        sd_ds,
  output logic              sd_we,
  output logic [SD_DW-1:0]  sd_d,
  input  logic [SD_DW-1:0]  sd_q
);

  localparam int DLW = 32;
  localparam int VRW = VR_AW + 19;

  // Edge detectors and capture bookkeeping.
  logic             dl_wr_q, dl_wr_d;
  logic             dl_active_q, dl_active_d;
  logic             rom_loaded_q, rom_loaded_d;
  logic             vr_act_q, vr_act_d;
  logic [VR_AW:0]   vr_last_q, vr_last_d;
  logic             dl_cap, vr_cap;

  // Pending slots.
  logic             dl_full, dl_clr, dl_ovr;
  logic [DLW-1:0]   dl_slot;
  logic             vr_full, vr_clr, vr_ovr_unused;
  logic [VRW-1:0]   vr_slot;
  logic [VR_AW-1:0] vr_s_addr;
  logic             vr_s_we;
  logic [1:0]       vr_s_cs;
  logic [15:0]      vr_s_din;

  // FSM and port registers.
  sched_state_e     state_q, state_d;
  sd_req_t          req_q, req_d;
  sd_req_t          dl_req, vr_req;
  logic             sd_req_q, sd_req_d;
  logic [15:0]      vr_dout_q, vr_dout_d;

`ifdef SDRAM_PORT_SCHED_RDCACHE_EN
  logic             cache_vld_q, cache_vld_d;
  logic [VR_AW-1:0] cache_addr_q, cache_addr_d;
  logic [VR_AW-1:0] infl_addr_q, infl_addr_d;
`endif

  // Capture triggers, edge history and the sticky ROM-loaded flag.
  always_comb begin
    dl_cap       = dl_active & dl_wr & ~dl_wr_q;
    vr_cap       = (|vr_cs) & (~vr_act_q | ({vr_addr, vr_we} != vr_last_q));
    dl_wr_d      = dl_wr;
    dl_active_d  = dl_active;
    vr_act_d     = |vr_cs;
    vr_last_d    = vr_cap ? {vr_addr, vr_we} : vr_last_q;
    rom_loaded_d = rom_loaded_q | (dl_active_q & ~dl_active);
  end

  // Capture history registers.
  always_ff @(posedge clk_sys or negedge RESET_L) begin
    if (!RESET_L) begin
      dl_wr_q      <= 1'b0;
      dl_active_q  <= 1'b0;
      rom_loaded_q <= 1'b0;
      vr_act_q     <= 1'b0;
      vr_last_q    <= '0;
    end else begin
      dl_wr_q      <= dl_wr_d;
      dl_active_q  <= dl_active_d;
      rom_loaded_q <= rom_loaded_d;
      vr_act_q     <= vr_act_d;
      vr_last_q    <= vr_last_d;
    end
  end

  sdram_req_slot #(.W(DLW)) u_dl_slot (
    .clk_sys (clk_sys),
    .rst_n   (RESET_L),
    .cap     (dl_cap),
    .clr     (dl_clr),
    .din     ({dl_addr, dl_data}),
    .full    (dl_full),
    .dout    (dl_slot),
    .ovr     (dl_ovr)
  );

  sdram_req_slot #(.W(VRW)) u_vr_slot (
    .clk_sys (clk_sys),
    .rst_n   (RESET_L),
    .cap     (vr_cap),
    .clr     (vr_clr),
    .din     ({vr_addr, vr_we, vr_cs, vr_din}),
    .full    (vr_full),
    .dout    (vr_slot),
    .ovr     (vr_ovr_unused)
  );

  // Unpack pending slots into SDRAM request records.
  always_comb begin
    vr_s_addr = vr_slot[VRW-1:19];
    vr_s_we   = vr_slot[18];
    vr_s_cs   = vr_slot[17:16];
    vr_s_din  = vr_slot[15:0];
    dl_req.a  = dl_slot[31:9];
    dl_req.ds = dl_lane(dl_slot[8]);
    dl_req.we = 1'b1;
    dl_req.d  = {dl_slot[7:0], dl_slot[7:0]};
    vr_req.a  = VR_BASE + SD_AW'(vr_s_addr);
    vr_req.ds = vr_s_cs;
    vr_req.we = vr_s_we;
    vr_req.d  = vr_s_din;
  end

  // Next-state, issue and completion logic.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    sd_req_d  = sd_req_q;
    vr_dout_d = vr_dout_q;
    dl_clr    = 1'b0;
    vr_clr    = 1'b0;
`ifdef SDRAM_PORT_SCHED_RDCACHE_EN
    cache_vld_d  = cache_vld_q;
    cache_addr_d = cache_addr_q;
    infl_addr_d  = infl_addr_q;
`endif
    case (state_q)
      IDLE: begin
        if (dl_full) begin
          req_d    = dl_req;
          sd_req_d = ~sd_req_q;
          dl_clr   = 1'b1;
          state_d  = WAIT_DL;
`ifdef SDRAM_PORT_SCHED_RDCACHE_EN
          cache_vld_d = 1'b0;
`endif
        end else if (vr_full && !dl_active) begin
`ifdef SDRAM_PORT_SCHED_RDCACHE_EN
          if (!vr_s_we && cache_vld_q && (vr_s_addr == cache_addr_q)) begin
            // Repeat read of unchanged data: retire it without an access.
            vr_clr = 1'b1;
          end else begin
            req_d       = vr_req;
            sd_req_d    = ~sd_req_q;
            vr_clr      = 1'b1;
            state_d     = WAIT_VR;
            infl_addr_d = vr_s_addr;
            if (vr_s_we) begin
              cache_vld_d = 1'b0;
            end
          end
`else
          req_d    = vr_req;
          sd_req_d = ~sd_req_q;
          vr_clr   = 1'b1;
          state_d  = WAIT_VR;
`endif
        end
      end
      WAIT_DL: begin
        if (sd_ack == sd_req_q) begin
          state_d = IDLE;
        end
      end
      WAIT_VR: begin
        if (sd_ack == sd_req_q) begin
          if (!req_q.we) begin
            vr_dout_d = sd_q;
`ifdef SDRAM_PORT_SCHED_RDCACHE_EN
            cache_vld_d  = 1'b1;
            cache_addr_d = infl_addr_q;
`endif
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and SDRAM port registers.
  always_ff @(posedge clk_sys or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q   <= IDLE;
      req_q     <= '0;
      sd_req_q  <= 1'b0;
      vr_dout_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      sd_req_q  <= sd_req_d;
      vr_dout_q <= vr_dout_d;
    end
  end

`ifdef SDRAM_PORT_SCHED_RDCACHE_EN
  // Read-cache tag registers.
  always_ff @(posedge clk_sys or negedge RESET_L) begin
    if (!RESET_L) begin
      cache_vld_q  <= 1'b0;
      cache_addr_q <= '0;
      infl_addr_q  <= '0;
    end else begin
      cache_vld_q  <= cache_vld_d;
      cache_addr_q <= cache_addr_d;
      infl_addr_q  <= infl_addr_d;
    end
  end
`endif

  assign sd_req     = sd_req_q;
  assign sd_a       = req_q.a;
  assign sd_ds      = req_q.ds;
  assign sd_we      = req_q.we;
  assign sd_d       = req_q.d;
  assign vr_dout    = vr_dout_q;
  assign vr_busy    = vr_full | (state_q == WAIT_VR);
  assign dl_overrun = dl_ovr;
  assign rom_loaded = rom_loaded_q;

endmodule

// File: tb/tb_sdram_port_sched.sv
// Bench for sdram_port_sched: a table of single transactions with
// hand-computed SDRAM port values, plus directed multi-cycle sequences.
module tb_sdram_port_sched;

  logic        clk_sys = 1'b0;
  logic        RESET_L = 1'b0;
  logic        dl_active = 1'b0;
  logic        dl_wr = 1'b0;
  logic [23:0] dl_addr = '0;
  logic [7:0]  dl_data = '0;
  logic        dl_overrun;
  logic        rom_loaded;
  logic [1:0]  vr_cs = '0;
  logic        vr_we = 1'b0;
  logic [9:0]  vr_addr = '0;
  logic [15:0] vr_din = '0;
  logic [15:0] vr_dout;
  logic        vr_busy;
  logic        sd_req;
  logic        sd_ack = 1'b0;
  logic [22:0] sd_a;
  logic [1:0]  sd_ds;
  logic        sd_we;
  logic [15:0] sd_d;
  logic [15:0] sd_q = '0;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic        is_vr;
    logic [23:0] dl_addr;
    logic [7:0]  dl_data;
    logic [1:0]  cs;
    logic [9:0]  vaddr;
    logic [15:0] din;
    logic [15:0] resp;
    logic [22:0] e_a;
    logic [1:0]  e_ds;
    logic        e_we;
    logic [15:0] e_d;
    logic [15:0] e_dout;
  } vec_t;

  vec_t tbl [8];

  sdram_port_sched dut (
    .clk_sys    (clk_sys),
    .RESET_L    (RESET_L),
    .dl_active  (dl_active),
    .dl_wr      (dl_wr),
    .dl_addr    (dl_addr),
    .dl_data    (dl_data),
    .dl_overrun (dl_overrun),
    .rom_loaded (rom_loaded),
    .vr_cs      (vr_cs),
    .vr_we      (vr_we),
    .vr_addr    (vr_addr),
    .vr_din     (vr_din),
    .vr_dout    (vr_dout),
    .vr_busy    (vr_busy),
    .sd_req     (sd_req),
    .sd_ack     (sd_ack),
    .sd_a       (sd_a),
    .sd_ds      (sd_ds),
    .sd_we      (sd_we),
    .sd_d       (sd_d),
    .sd_q       (sd_q)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_issue(input string nm, input logic prev);
    int n = 0;
    while (sd_req == prev && n < 20) begin
      tick();
      n++;
    end
    chk(nm, 64'(sd_req), 64'(!prev));
  endtask

  task automatic complete(input logic [15:0] resp);
    sd_q   = resp;
    sd_ack = sd_req;
    tick();
  endtask

  task automatic dl_pulse(input logic [23:0] a, input logic [7:0] d);
    dl_addr = a;
    dl_data = d;
    dl_wr   = 1'b1;
    tick();
    dl_wr   = 1'b0;
  endtask

  task automatic vr_access(input logic [1:0] cs, input logic we, input logic [9:0] a,
                           input logic [15:0] din);
    vr_cs   = cs;
    vr_we   = we;
    vr_addr = a;
    vr_din  = din;
    tick();
    vr_cs   = 2'b00;
  endtask

  initial begin
    logic prev;
    logic exp_req;
    vec_t v;

    //          vr    dl_addr      dl_d   cs     vaddr    din       resp      e_a           ds     we    e_d       e_dout
    tbl[0] = '{1'b0, 24'h000005, 8'hA5, 2'b00, 10'h000, 16'h0000, 16'h0000, 23'h000002, 2'b10, 1'b1, 16'hA5A5, 16'h4321};
    tbl[1] = '{1'b0, 24'h123456, 8'h3C, 2'b00, 10'h000, 16'h0000, 16'h0000, 23'h091A2B, 2'b01, 1'b1, 16'h3C3C, 16'h4321};
    tbl[2] = '{1'b0, 24'hFFFFFF, 8'hFF, 2'b00, 10'h000, 16'h0000, 16'h0000, 23'h7FFFFF, 2'b10, 1'b1, 16'hFFFF, 16'h4321};
    tbl[3] = '{1'b1, 24'h000000, 8'h00, 2'b11, 10'h03F, 16'h0000, 16'h1234, 23'h01003F, 2'b11, 1'b0, 16'h0000, 16'h1234};
    tbl[4] = '{1'b1, 24'h000000, 8'h00, 2'b01, 10'h3FF, 16'hBEEF, 16'h5555, 23'h0103FF, 2'b01, 1'b1, 16'hBEEF, 16'h1234};
    tbl[5] = '{1'b1, 24'h000000, 8'h00, 2'b10, 10'h000, 16'h0000, 16'hABCD, 23'h010000, 2'b10, 1'b0, 16'h0000, 16'hABCD};
    tbl[6] = '{1'b1, 24'h000000, 8'h00, 2'b11, 10'h155, 16'h1357, 16'h2468, 23'h010155, 2'b11, 1'b1, 16'h1357, 16'hABCD};
    tbl[7] = '{1'b1, 24'h000000, 8'h00, 2'b01, 10'h2AA, 16'h0000, 16'h0F0F, 23'h0102AA, 2'b01, 1'b0, 16'h0000, 16'h0F0F};

    tick();
    tick();
    RESET_L = 1'b1;
    tick();

    chk("rst_sd_req", 64'(sd_req), 64'd0);
    chk("rst_sd_a", 64'(sd_a), 64'd0);
    chk("rst_sd_ds", 64'(sd_ds), 64'd0);
    chk("rst_sd_we", 64'(sd_we), 64'd0);
    chk("rst_sd_d", 64'(sd_d), 64'd0);
    chk("rst_vr_dout", 64'(vr_dout), 64'd0);
    chk("rst_vr_busy", 64'(vr_busy), 64'd0);
    chk("rst_overrun", 64'(dl_overrun), 64'd0);
    chk("rst_rom_loaded", 64'(rom_loaded), 64'd0);

    // VR held off while downloading, released by dl_active falling.
    dl_active = 1'b1;
    tick();
    vr_access(2'b11, 1'b0, 10'h010, 16'h0000);
    chk("blk_busy", 64'(vr_busy), 64'd1);
    repeat (5) tick();
    chk("blk_no_issue", 64'(sd_req), 64'd0);
    chk("blk_rom_pre", 64'(rom_loaded), 64'd0);
    dl_active = 1'b0;
    tick();
    chk("blk_rom_loaded", 64'(rom_loaded), 64'd1);
    chk("blk_issue", 64'(sd_req), 64'd1);
    chk("blk_addr", 64'(sd_a), 64'h010010);
    chk("blk_we", 64'(sd_we), 64'd0);
    complete(16'h4321);
    chk("blk_dout", 64'(vr_dout), 64'h4321);
    chk("blk_busy_done", 64'(vr_busy), 64'd0);

    // Table of single transactions.
    for (int i = 0; i < 8; i++) begin
      v    = tbl[i];
      prev = sd_req;
      if (!v.is_vr) begin
        dl_active = 1'b1;
        dl_pulse(v.dl_addr, v.dl_data);
      end else begin
        dl_active = 1'b0;
        vr_access(v.cs, v.e_we, v.vaddr, v.din);
      end
      wait_issue($sformatf("v%0d_issue", i), prev);
      chk($sformatf("v%0d_a", i), 64'(sd_a), 64'(v.e_a));
      chk($sformatf("v%0d_ds", i), 64'(sd_ds), 64'(v.e_ds));
      chk($sformatf("v%0d_we", i), 64'(sd_we), 64'(v.e_we));
      chk($sformatf("v%0d_d", i), 64'(sd_d), 64'(v.e_d));
      tick();
      tick();
      chk($sformatf("v%0d_a_stable", i), 64'(sd_a), 64'(v.e_a));
      chk($sformatf("v%0d_d_stable", i), 64'(sd_d), 64'(v.e_d));
      complete(v.resp);
      chk($sformatf("v%0d_dout", i), 64'(vr_dout), 64'(v.e_dout));
      chk($sformatf("v%0d_busy", i), 64'(vr_busy), 64'd0);
      tick();
    end

    // Overrun: two bytes captured while the first write is unacknowledged.
    dl_active = 1'b1;
    prev = sd_req;
    dl_pulse(24'h000020, 8'h00);
    wait_issue("ovr_first_issue", prev);
    dl_pulse(24'h000031, 8'hAA);
    tick();
    chk("ovr_pre", 64'(dl_overrun), 64'd0);
    dl_pulse(24'h000042, 8'hBB);
    tick();
    chk("ovr_set", 64'(dl_overrun), 64'd1);
    prev = sd_req;
    complete(16'h0000);
    wait_issue("ovr_second_issue", prev);
    chk("ovr_second_a", 64'(sd_a), 64'h000021);
    chk("ovr_second_ds", 64'(sd_ds), 64'h1);
    chk("ovr_second_d", 64'(sd_d), 64'hBBBB);
    complete(16'h0000);
    repeat (5) tick();
    exp_req = !prev;
    chk("ovr_first_lost", 64'(sd_req), 64'(exp_req));
    chk("ovr_sticky", 64'(dl_overrun), 64'd1);

    // Priority: DL and VR captured together, DL first, VR right after ack.
    dl_active = 1'b1;
    dl_addr   = 24'h000101;
    dl_data   = 8'h5A;
    dl_wr     = 1'b1;
    vr_cs     = 2'b11;
    vr_we     = 1'b0;
    vr_addr   = 10'h077;
    vr_din    = 16'h0000;
    prev      = sd_req;
    tick();
    dl_wr     = 1'b0;
    vr_cs     = 2'b00;
    dl_active = 1'b0;
    chk("pri_busy", 64'(vr_busy), 64'd1);
    chk("pri_none_yet", 64'(sd_req), 64'(prev));
    tick();
    exp_req = !prev;
    chk("pri_dl_first", 64'(sd_req), 64'(exp_req));
    chk("pri_dl_we", 64'(sd_we), 64'd1);
    chk("pri_dl_a", 64'(sd_a), 64'h000080);
    chk("pri_dl_ds", 64'(sd_ds), 64'h2);
    chk("pri_dl_d", 64'(sd_d), 64'h5A5A);
    complete(16'h0000);
    chk("pri_gap", 64'(sd_req), 64'(exp_req));
    tick();
    chk("pri_vr_next", 64'(sd_req), 64'(prev));
    chk("pri_vr_a", 64'(sd_a), 64'h010077);
    chk("pri_vr_we", 64'(sd_we), 64'd0);
    complete(16'h9999);
    chk("pri_vr_dout", 64'(vr_dout), 64'h9999);
    chk("pri_vr_busy", 64'(vr_busy), 64'd0);
    tick();

    // Reset while a vector read is in flight.
    prev = sd_req;
    vr_access(2'b01, 1'b0, 10'h055, 16'h0000);
    wait_issue("rst_mid_issue", prev);
    chk("rst_mid_busy", 64'(vr_busy), 64'd1);
    RESET_L = 1'b0;
    sd_ack  = 1'b0;
    #1;
    chk("rst_mid_sd_req", 64'(sd_req), 64'd0);
    chk("rst_mid_sd_a", 64'(sd_a), 64'd0);
    chk("rst_mid_sd_ds", 64'(sd_ds), 64'd0);
    chk("rst_mid_sd_we", 64'(sd_we), 64'd0);
    chk("rst_mid_sd_d", 64'(sd_d), 64'd0);
    chk("rst_mid_vr_dout", 64'(vr_dout), 64'd0);
    chk("rst_mid_vr_busy", 64'(vr_busy), 64'd0);
    chk("rst_mid_overrun", 64'(dl_overrun), 64'd0);
    chk("rst_mid_rom", 64'(rom_loaded), 64'd0);
    tick();
    tick();
    RESET_L = 1'b1;
    repeat (6) tick();
    chk("rst_post_no_req", 64'(sd_req), 64'd0);
    chk("rst_post_busy", 64'(vr_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
